// File: rtl/asmd_mult_arbiter_if.sv
// asmd_mult_arbiter_if: requester-side bus of the shared multiplier arbiter
// Ports (slave = arbiter side):
//   req        requests, one bit per requester, held until done
//   req_word0  operand A per requester, slice i = requester i
//   req_word1  operand B per requester
//   gnt        one-hot grant, held for the whole transaction
//   done       one-cycle completion pulse to the owner
//   result     last product, held until the next completion
//   busy       arbiter not idle
interface asmd_mult_arbiter_if #(parameter int word_length = 4, parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req, gnt, done;
  logic [NUM_REQ*word_length-1:0] req_word0, req_word1;
  logic [2*word_length-1:0] result;
  logic busy;
  modport master(output req, req_word0, req_word1, input gnt, done, result, busy);
  modport slave(input req, req_word0, req_word1, output gnt, done, result, busy);
endinterface

// File: rtl/asmd_mult_arbiter.sv
// asmd_mult_arbiter: round-robin sharing of one asmd_multiplier between NUM_REQ requesters
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   bus                      requester bus (slave modport)
//   mul_start                one-cycle start pulse to the multiplier
//   mul_word0, mul_word1     operands latched from the granted requester
//   mul_ready, mul_product   multiplier handshake and product
module asmd_mult_arbiter #(
  parameter int word_length = 4,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  asmd_mult_arbiter_if.slave bus,
  output logic mul_start,
  output logic [word_length-1:0] mul_word0,
  output logic [word_length-1:0] mul_word1,
  input  logic mul_ready,
  input  logic [2*word_length-1:0] mul_product
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [2*word_length-1:0] result_q, result_d;
  logic [word_length-1:0] w0_q, w0_d, w1_q, w1_d;
  logic start_q, start_d, busy_q, busy_d;
  // Scan from the farthest offset down so the first requester at or after ptr wins.
  always_comb begin
    pick = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(ptr_q) + k) % NUM_REQ]) pick = IW'((int'(ptr_q) + k) % NUM_REQ);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    done_d = '0;
    result_d = result_q;
    w0_d = w0_q;
    w1_d = w1_q;
    start_d = 1'b0;
    case (state_q)
      IDLE:
        if (|bus.req && mul_ready) begin
          state_d = WAIT_LOW;
          owner_d = pick;
          gnt_d = NUM_REQ'(1) << pick;
          w0_d = bus.req_word0[int'(pick)*word_length +: word_length];
          w1_d = bus.req_word1[int'(pick)*word_length +: word_length];
          start_d = 1'b1;
          cnt_d = '0;
        end
      WAIT_LOW:
        if (!mul_ready) state_d = WAIT_HIGH;
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Multiplier never acknowledged the start; pulse it again.
          start_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + CW'(1);
      WAIT_HIGH:
        if (mul_ready) begin
          state_d = DONE;
          result_d = mul_product;
          done_d = NUM_REQ'(1) << owner_q;
          gnt_d = '0;
          ptr_d = IW'((int'(owner_q) + 1) % NUM_REQ);
        end
      DONE: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      result_q <= '0;
      w0_q <= '0;
      w1_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      result_q <= result_d;
      w0_q <= w0_d;
      w1_q <= w1_d;
      start_q <= start_d;
      busy_q <= busy_d;
    end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.result = result_q;
  assign bus.busy = busy_q;
  assign mul_start = start_q;
  assign mul_word0 = w0_q;
  assign mul_word1 = w1_q;
endmodule

// File: tb/tb_asmd_mult_arbiter.sv
// tb_asmd_mult_arbiter: scoreboard bench for asmd_mult_arbiter with a behavioural multiplier
`timescale 1ns/1ps
module tb_asmd_mult_arbiter;
  localparam int WL = 4;
  localparam int NR = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  asmd_mult_arbiter_if #(.word_length(WL), .NUM_REQ(NR)) bus();
  logic mul_start, mul_ready, m_ready, stub, stub_ready;
  logic [WL-1:0] mul_word0, mul_word1, ma, mb;
  logic [2*WL-1:0] mul_product, m_product, stub_product;
  int mcnt;
  asmd_mult_arbiter #(.word_length(WL), .NUM_REQ(NR), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mul_start(mul_start), .mul_word0(mul_word0), .mul_word1(mul_word1),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );
  assign mul_ready = stub ? stub_ready : m_ready;
  assign mul_product = stub ? stub_product : m_product;
  // Behavioural multiplier: ready drops on start, product appears 3 cycles later.
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_ready <= 1'b1;
      m_product <= '0;
      mcnt <= 0;
      ma <= '0;
      mb <= '0;
    end else if (!stub) begin
      if (m_ready && mul_start) begin
        m_ready <= 1'b0;
        mcnt <= 3;
        ma <= mul_word0;
        mb <= mul_word1;
      end else if (!m_ready) begin
        if (mcnt == 1) begin
          m_ready <= 1'b1;
          m_product <= 8'(ma) * 8'(mb);
        end
        mcnt <= mcnt - 1;
      end
    end
  typedef struct {int idx; logic [2*WL-1:0] res;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  int starts = 0, done_count = 0;
  int gnt_cycles[NR];
  initial foreach (gnt_cycles[i]) gnt_cycles[i] = 0;
  always @(negedge clk)
    if (!reset) begin
      checks++;
      if ($countones(bus.gnt) > 1) begin
        errors++;
        $display("FAIL gnt_onehot: gnt=%b, required at most one bit", bus.gnt);
      end
      if (mul_start) starts++;
      for (int i = 0; i < NR; i++) if (bus.gnt[i]) gnt_cycles[i]++;
      if (|bus.done) begin
        done_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=%b result=%0d, required no done", bus.done, bus.result);
        end else begin
          e = sb.pop_front();
          if (bus.done !== NR'(1) << e.idx || bus.result !== e.res) begin
            errors++;
            $display("FAIL done_result: done=%b result=%0d, required done[%0d] result=%0d",
                     bus.done, bus.result, e.idx, e.res);
          end
        end
      end
    end
  task automatic issue(int idx, logic [WL-1:0] a, logic [WL-1:0] b, logic [2*WL-1:0] r);
    bus.req_word0[idx*WL +: WL] = a;
    bus.req_word1[idx*WL +: WL] = b;
    sb.push_back('{idx: idx, res: r});
    bus.req[idx] = 1'b1;
  endtask
  task automatic wait_done(int idx);
    int n = 0;
    @(negedge clk);
    while (!bus.done[idx] && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.done[idx]) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required done[%0d]", bus.done, n, idx);
    end
  endtask
  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, g0, d0, n;
    bus.req = '0;
    bus.req_word0 = '0;
    bus.req_word1 = '0;
    stub = 1'b0;
    stub_ready = 1'b1;
    stub_product = 8'hA5;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({bus.gnt, bus.done, bus.result, bus.busy, mul_start, mul_word0, mul_word1}), 0);
    reset = 1'b0;
    @(negedge clk);
    // T1: single request, 4*5
    s0 = starts;
    issue(0, 4'd4, 4'd5, 8'd20);
    wait_done(0);
    bus.req[0] = 1'b0;
    check("t1_start_pulses", starts - s0, 1);
    repeat (2) @(negedge clk);
    check("t1_idle_busy", int'(bus.busy), 0);
    // T2: requester 1 alone, 15*15
    g0 = gnt_cycles[0];
    issue(1, 4'd15, 4'd15, 8'hE1);
    wait_done(1);
    bus.req[1] = 1'b0;
    check("t2_no_gnt0", gnt_cycles[0] - g0, 0);
    repeat (2) @(negedge clk);
    // T3: both held, pointer at 0 -> 0,1,0
    issue(0, 4'd3, 4'd7, 8'd21);
    issue(1, 4'd2, 4'd6, 8'd12);
    sb.push_back('{idx: 0, res: 8'd21});
    wait_done(0);
    wait_done(1);
    wait_done(0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("t3_scoreboard_drained", sb.size(), 0);
    // T4: reset while in WAIT_HIGH; the aborted transaction must not complete
    bus.req_word0[WL +: WL] = 4'd15;
    bus.req_word1[WL +: WL] = 4'd15;
    bus.req[1] = 1'b1;
    n = 0;
    while (mul_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t4_pre_gnt", int'(bus.gnt), 2);
    reset = 1'b1;
    #1;
    check("t4_reset_outputs", int'({bus.gnt, bus.done, bus.result, bus.busy, mul_start, mul_word0, mul_word1}), 0);
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    d0 = done_count;
    repeat (10) @(negedge clk);
    check("t4_no_done", done_count - d0, 0);
    issue(0, 4'd15, 4'd15, 8'd225);
    wait_done(0);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    // T5: zero operand then identity
    issue(1, 4'd0, 4'd13, 8'd0);
    wait_done(1);
    bus.req[1] = 1'b0;
    repeat (2) @(negedge clk);
    issue(0, 4'd13, 4'd1, 8'd13);
    wait_done(0);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    // T6: stuck-ready stub -> start re-pulses every 8 cycles, no done
    stub = 1'b1;
    stub_ready = 1'b1;
    s0 = starts;
    d0 = done_count;
    issue(1, 4'd6, 4'd7, 8'hA5);
    repeat (32) @(negedge clk);
    check("t6_start_repulses", starts - s0, 4);
    check("t6_no_done", done_count - d0, 0);
    stub_ready = 1'b0;
    repeat (2) @(negedge clk);
    stub_ready = 1'b1;
    wait_done(1);
    bus.req[1] = 1'b0;
    stub = 1'b0;
    repeat (3) @(negedge clk);
    check("final_scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
